// File: rtl/dt_commit_pkg.sv
// Shared types and constants for the difftest instruction-commit generator.
// Defines the merged commit record, the merge FSM states, and field widths
// used by difftest_commit_gen and its sub-modules.
package dt_commit_pkg;

   localparam int NFUSED_MAX = 255;
   localparam int ROBIDX_W   = 10;
   localparam int LSQIDX_W   = 7;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_MERGE = 1'b1
   } merge_state_t;

   typedef struct packed {
      logic                skip;
      logic                isRVC;
      logic                rfwen;
      logic                fpwen;
      logic                vecwen;
      logic                isLoad;
      logic                isStore;
      logic [4:0]          wpdest;
      logic [7:0]          wdest;
      logic [63:0]         pc;
      logic [31:0]         instr;
      logic [ROBIDX_W-1:0] robIdx;
      logic [LSQIDX_W-1:0] lqIdx;
      logic [LSQIDX_W-1:0] sqIdx;
      logic [7:0]          nFused;
      logic [7:0]          special;
   } commit_rec_t;

endpackage

// File: rtl/dt_commit_watchdog.sv
// No-commit watchdog: counts cycles since the last emitted record,
// saturating at TIMEOUT, and raises a sticky error flag when the count
// reaches TIMEOUT. Only reset clears the flag.
//   clock     : clock
//   reset     : asynchronous active-high reset
//   kick      : a record is emitted this cycle (restarts the count)
//   stall_err : sticky watchdog flag
module dt_commit_watchdog #(
   parameter int TIMEOUT = 5000
) (
   input  logic clock,
   input  logic reset,
   input  logic kick,
   output logic stall_err
);

   localparam int            CW    = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] idle_cnt_p1;
   logic          err_p1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idle_cnt_p1 <= '0;
         err_p1      <= 1'b0;
      end else begin
         if (kick) begin
            idle_cnt_p1 <= '0;
         end else if (idle_cnt_p1 != LIMIT) begin
            idle_cnt_p1 <= idle_cnt_p1 + 1'b1;
         end
         // Flag rises on the same edge the count lands on TIMEOUT.
         if (!kick && (idle_cnt_p1 == LIMIT - 1'b1)) begin
            err_p1 <= 1'b1;
         end
      end
   end

   assign stall_err = err_p1;

endmodule

// File: rtl/difftest_commit_gen.sv
// Difftest commit-channel generator. Merges the retired micro-ops of one
// architectural instruction into a single commit record and drives it,
// registered, one cycle after the last micro-op. Also keeps the
// retired-instruction counter and the no-commit watchdog.
//   clock, reset            : clock, asynchronous active-high reset
//   uop_*                   : ROB retire port, one micro-op per cycle
//   dt_*                    : registered commit record toward the DPI sink
//   instret                 : count of emitted records (wraps at 2^64)
//   stall_err               : sticky no-commit watchdog flag
module difftest_commit_gen
   import dt_commit_pkg::*;
#(
   parameter int COREID  = 0,
   parameter int INDEX   = 0,
   parameter int TIMEOUT = 5000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                uop_valid,
   input  logic                uop_last,
   input  logic                uop_flush,
   input  logic                uop_skip,
   input  logic                uop_isRVC,
   input  logic                uop_rfwen,
   input  logic                uop_fpwen,
   input  logic                uop_vecwen,
   input  logic                uop_isLoad,
   input  logic                uop_isStore,
   input  logic [4:0]          uop_wpdest,
   input  logic [7:0]          uop_wdest,
   input  logic [63:0]         uop_pc,
   input  logic [31:0]         uop_instr,
   input  logic [ROBIDX_W-1:0] uop_robIdx,
   input  logic [LSQIDX_W-1:0] uop_lqIdx,
   input  logic [LSQIDX_W-1:0] uop_sqIdx,
   input  logic [7:0]          uop_special,
   output logic                dt_enable,
   output logic                dt_valid,
   output logic                dt_skip,
   output logic                dt_isRVC,
   output logic                dt_rfwen,
   output logic                dt_fpwen,
   output logic                dt_vecwen,
   output logic                dt_isLoad,
   output logic                dt_isStore,
   output logic [4:0]          dt_wpdest,
   output logic [7:0]          dt_wdest,
   output logic [63:0]         dt_pc,
   output logic [31:0]         dt_instr,
   output logic [ROBIDX_W-1:0] dt_robIdx,
   output logic [LSQIDX_W-1:0] dt_lqIdx,
   output logic [LSQIDX_W-1:0] dt_sqIdx,
   output logic [7:0]          dt_nFused,
   output logic [7:0]          dt_special,
   output logic [7:0]          dt_coreid,
   output logic [7:0]          dt_index,
   output logic [63:0]         instret,
   output logic                stall_err
);

   function automatic logic [7:0] sat_inc_nfused(input logic [7:0] c);
      return (c == 8'(NFUSED_MAX)) ? c : c + 8'd1;
   endfunction

   merge_state_t state, state_n;
   commit_rec_t  acc, acc_n;
   commit_rec_t  uop_rec_p0, merged_p0, rec_p0;
   logic         emit_p0;
   commit_rec_t  rec_p1;
   logic         vld_p1;
   logic [63:0]  instret_p1;

   // Stage p0: current uop viewed as a record, and the accumulator with it folded in.
   always_comb begin
      uop_rec_p0         = '0;
      uop_rec_p0.skip    = uop_skip;
      uop_rec_p0.isRVC   = uop_isRVC;
      uop_rec_p0.rfwen   = uop_rfwen;
      uop_rec_p0.fpwen   = uop_fpwen;
      uop_rec_p0.vecwen  = uop_vecwen;
      uop_rec_p0.isLoad  = uop_isLoad;
      uop_rec_p0.isStore = uop_isStore;
      uop_rec_p0.wpdest  = uop_wpdest;
      uop_rec_p0.wdest   = uop_wdest;
      uop_rec_p0.pc      = uop_pc;
      uop_rec_p0.instr   = uop_instr;
      uop_rec_p0.robIdx  = uop_robIdx;
      uop_rec_p0.lqIdx   = uop_lqIdx;
      uop_rec_p0.sqIdx   = uop_sqIdx;
      uop_rec_p0.special = uop_special;

      // pc/instr/isRVC/robIdx stay from the first uop; LSQ indices track the latest.
      merged_p0         = acc;
      merged_p0.nFused  = sat_inc_nfused(acc.nFused);
      merged_p0.skip    = acc.skip    | uop_skip;
      merged_p0.rfwen   = acc.rfwen   | uop_rfwen;
      merged_p0.fpwen   = acc.fpwen   | uop_fpwen;
      merged_p0.vecwen  = acc.vecwen  | uop_vecwen;
      merged_p0.isLoad  = acc.isLoad  | uop_isLoad;
      merged_p0.isStore = acc.isStore | uop_isStore;
      merged_p0.lqIdx   = uop_lqIdx;
      merged_p0.sqIdx   = uop_sqIdx;
      if (uop_rfwen | uop_fpwen | uop_vecwen) begin
         merged_p0.wpdest = uop_wpdest;
         merged_p0.wdest  = uop_wdest;
      end
      if (uop_special != 8'd0) begin
         merged_p0.special = uop_special;
      end
   end

   always_comb begin
      state_n = state;
      acc_n   = acc;
      emit_p0 = 1'b0;
      rec_p0  = uop_rec_p0;
      if (uop_flush) begin
         state_n = ST_IDLE;
         acc_n   = '0;
      end else if (uop_valid) begin
         case (state)
            ST_IDLE: begin
               if (uop_last) begin
                  emit_p0 = 1'b1;
               end else begin
                  acc_n   = uop_rec_p0;
                  state_n = ST_MERGE;
               end
            end
            ST_MERGE: begin
               if (uop_last) begin
                  emit_p0 = 1'b1;
                  rec_p0  = merged_p0;
                  acc_n   = '0;
                  state_n = ST_IDLE;
               end else begin
                  acc_n = merged_p0;
               end
            end
            default: begin
               state_n = ST_IDLE;
               acc_n   = '0;
            end
         endcase
      end
   end

   // Stage p1: registered record, strobe and retired-instruction counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         acc        <= '0;
         rec_p1     <= '0;
         vld_p1     <= 1'b0;
         instret_p1 <= '0;
      end else begin
         state  <= state_n;
         acc    <= acc_n;
         vld_p1 <= emit_p0;
         if (emit_p0) begin
            rec_p1     <= rec_p0;
            instret_p1 <= instret_p1 + 64'd1;
         end
      end
   end

   dt_commit_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clock     (clock),
      .reset     (reset),
      .kick      (emit_p0),
      .stall_err (stall_err)
   );

   assign dt_enable  = vld_p1;
   assign dt_valid   = vld_p1;
   assign dt_skip    = rec_p1.skip;
   assign dt_isRVC   = rec_p1.isRVC;
   assign dt_rfwen   = rec_p1.rfwen;
   assign dt_fpwen   = rec_p1.fpwen;
   assign dt_vecwen  = rec_p1.vecwen;
   assign dt_isLoad  = rec_p1.isLoad;
   assign dt_isStore = rec_p1.isStore;
   assign dt_wpdest  = rec_p1.wpdest;
   assign dt_wdest   = rec_p1.wdest;
   assign dt_pc      = rec_p1.pc;
   assign dt_instr   = rec_p1.instr;
   assign dt_robIdx  = rec_p1.robIdx;
   assign dt_lqIdx   = rec_p1.lqIdx;
   assign dt_sqIdx   = rec_p1.sqIdx;
   assign dt_nFused  = rec_p1.nFused;
   assign dt_special = rec_p1.special;
   assign dt_coreid  = 8'(COREID);
   assign dt_index   = 8'(INDEX);
   assign instret    = instret_p1;

endmodule
